// File: rtl/sram_responder.sv
// sram_responder: clocked model of an asynchronous-mode cellular RAM device,
// seen from the far side of the SRAM bus of the controller.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   sram_clk/adv/cre/ce/oe/we/lb/ub
//                      device pins; all active-low except sram_cre
//   sram_addr [23:1]   half-word address, only [AW:1] decoded
//   sram_data [15:0]   shared data bus, driven only during a read phase
//   bcr [22:0]         bus configuration register (written via cre writes)
//   wr_count, rd_count saturating counts of array writes and read accesses
//   err, err_code      sticky protocol flags: bit0 short WE pulse,
//                      bit1 addr/data moved under WE, bit2 sync-mode attempt
module sram_responder #(
   parameter int          AW       = 10,
   parameter int          READ_LAT = 2,
   parameter int          WR_MIN   = 2,
   parameter logic [15:0] BAD_DATA = 16'hBAD0,
   parameter logic [22:0] BCR_RST  = 23'h009D1F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sram_clk,
   input  logic        sram_adv,
   input  logic        sram_cre,
   input  logic        sram_ce,
   input  logic        sram_oe,
   input  logic        sram_we,
   input  logic        sram_lb,
   input  logic        sram_ub,
   input  logic [23:1] sram_addr,
   inout  wire  [15:0] sram_data,
   output logic [22:0] bcr,
   output logic [15:0] wr_count,
   output logic [15:0] rd_count,
   output logic        err,
   output logic [2:0]  err_code
);

   localparam logic [7:0] RD_LAT_C = 8'(READ_LAT);
   localparam logic [7:0] WR_MIN_C = 8'(WR_MIN);

   logic [15:0] mem [0:(1<<AW)-1];

   logic        pend;
   logic        pend_cre;
   logic        pend_lb;
   logic        pend_ub;
   logic [23:1] pend_addr;
   logic [15:0] pend_data;
   logic [7:0]  we_cnt;

   logic [7:0]  stab_cnt;
   logic [23:1] last_addr;
   logic        prev_rd;

   logic        sel;
   logic        wr_phase;
   logic        rd_phase;
   logic        commit;
   logic        we_ok;
   logic        mem_we;
   logic        addr_same;
   logic        rd_valid;
   logic        drv;
   logic [15:0] rd_word;
   logic [15:0] rd_val;
   logic [2:0]  err_set;

   assign sel      = !sram_ce && !sram_adv;
   assign wr_phase = sel && !sram_we;
   assign rd_phase = sel && sram_we && !sram_oe && !sram_cre;
   // Commit on the trailing edge of WE, or when the controller deselects.
   assign commit   = pend && (!sel || sram_we);
   assign we_ok    = we_cnt >= WR_MIN_C;
   assign mem_we   = commit && we_ok && !pend_cre && !rst;

   // Address counts as stable only if the previous cycle was a read of it.
   assign addr_same = prev_rd && (sram_addr == last_addr);
   assign rd_valid  = addr_same && (stab_cnt >= RD_LAT_C);
   assign rd_word   = mem[sram_addr[AW:1]];
   assign rd_val    = rd_valid ? {(sram_ub ? 8'h00 : rd_word[15:8]),
                                  (sram_lb ? 8'h00 : rd_word[7:0])}
                               : BAD_DATA;
   assign drv       = rd_phase && !rst;
   assign sram_data = drv ? rd_val : 16'hzzzz;

   always_comb begin
      err_set    = 3'b000;
      err_set[2] = sel && sram_clk;
      err_set[1] = wr_phase && pend &&
                   ((sram_addr != pend_addr) || (sram_data != pend_data));
      err_set[0] = commit && !we_ok;
   end

   assign err = |err_code;

   // Array has no reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         if (!pend_lb) mem[pend_addr[AW:1]][7:0]  <= pend_data[7:0];
         if (!pend_ub) mem[pend_addr[AW:1]][15:8] <= pend_data[15:8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcr       <= BCR_RST;
         wr_count  <= 16'h0000;
         rd_count  <= 16'h0000;
         err_code  <= 3'b000;
         pend      <= 1'b0;
         pend_cre  <= 1'b0;
         pend_lb   <= 1'b1;
         pend_ub   <= 1'b1;
         pend_addr <= '0;
         pend_data <= 16'h0000;
         we_cnt    <= 8'h00;
         stab_cnt  <= 8'h00;
         last_addr <= '0;
         prev_rd   <= 1'b0;
      end else begin
         err_code <= err_code | err_set;

         if (wr_phase) begin
            pend_addr <= sram_addr;
            pend_data <= sram_data;
            pend_lb   <= sram_lb;
            pend_ub   <= sram_ub;
            pend_cre  <= sram_cre;
            pend      <= 1'b1;
            if (we_cnt != 8'hFF) we_cnt <= we_cnt + 8'h01;
         end else if (commit) begin
            pend   <= 1'b0;
            we_cnt <= 8'h00;
            if (we_ok) begin
               if (pend_cre) begin
                  bcr <= pend_addr;
               end else if (wr_count != 16'hFFFF) begin
                  wr_count <= wr_count + 16'h0001;
               end
            end
         end

         if (rd_phase) begin
            last_addr <= sram_addr;
            if (addr_same) begin
               if (stab_cnt != 8'hFF) stab_cnt <= stab_cnt + 8'h01;
            end else begin
               stab_cnt <= 8'h00;
               if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'h0001;
            end
         end
         prev_rd <= rd_phase;
      end
   end

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sram_clk = 1'b0;
   logic        sram_adv = 1'b1;
   logic        sram_cre = 1'b0;
   logic        sram_ce  = 1'b1;
   logic        sram_oe  = 1'b1;
   logic        sram_we  = 1'b1;
   logic        sram_lb  = 1'b0;
   logic        sram_ub  = 1'b0;
   logic [23:1] sram_addr = '0;
   wire  [15:0] sram_data;
   logic [22:0] bcr;
   logic [15:0] wr_count;
   logic [15:0] rd_count;
   logic        err;
   logic [2:0]  err_code;

   logic        tb_en = 1'b0;
   logic [15:0] tb_dq = 16'h0000;
   logic [15:0] got;

   int checks = 0;
   int errors = 0;

   assign sram_data = tb_en ? tb_dq : 16'hzzzz;

   always #5 clk = ~clk;

   sram_responder dut (
      .clk(clk), .rst(rst), .sram_clk(sram_clk), .sram_adv(sram_adv),
      .sram_cre(sram_cre), .sram_ce(sram_ce), .sram_oe(sram_oe),
      .sram_we(sram_we), .sram_lb(sram_lb), .sram_ub(sram_ub),
      .sram_addr(sram_addr), .sram_data(sram_data), .bcr(bcr),
      .wr_count(wr_count), .rd_count(rd_count), .err(err), .err_code(err_code)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // All pin changes happen at negedge; tasks are entered at a negedge.
   task automatic idle();
      sram_ce = 1'b1; sram_adv = 1'b1; sram_we = 1'b1; sram_oe = 1'b1;
      sram_cre = 1'b0; sram_lb = 1'b0; sram_ub = 1'b0; sram_clk = 1'b0;
      tb_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic wr(input logic [23:1] a, input logic [15:0] d,
                     input logic lb, input logic ub, input logic cre, input int n);
      sram_ce = 1'b0; sram_adv = 1'b0; sram_we = 1'b0; sram_oe = 1'b1;
      sram_cre = cre; sram_lb = lb; sram_ub = ub; sram_addr = a;
      tb_dq = d; tb_en = 1'b1;
      repeat (n) @(negedge clk);
      idle();
   endtask

   // Holds the address across three edges so stab_cnt reaches READ_LAT.
   task automatic rd(input logic [23:1] a, input logic lb, input logic ub,
                     output logic [15:0] q);
      tb_en = 1'b0;
      sram_ce = 1'b0; sram_adv = 1'b0; sram_we = 1'b1; sram_oe = 1'b0;
      sram_cre = 1'b0; sram_lb = lb; sram_ub = ub; sram_addr = a;
      repeat (3) @(negedge clk);
      q = sram_data;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_bcr", 32'(bcr), 32'h009D1F);
      chk("rst_wr_count", 32'(wr_count), 32'h0);
      chk("rst_rd_count", 32'(rd_count), 32'h0);
      chk("rst_err", 32'({err, err_code}), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // 32-bit write of 0x12345678 at byte 0x40, then readback
      wr(23'h000020, 16'h1234, 1'b0, 1'b0, 1'b0, 2);
      wr(23'h000021, 16'h5678, 1'b0, 1'b0, 1'b0, 2);
      chk("wr32_count", 32'(wr_count), 32'h2);
      rd(23'h000020, 1'b0, 1'b0, got);
      chk("rd32_hi", 32'(got), 32'h1234);
      rd(23'h000021, 1'b0, 1'b0, got);
      chk("rd32_lo", 32'(got), 32'h5678);
      chk("rd32_count", 32'(rd_count), 32'h2);
      chk("rd32_err", 32'(err), 32'h0);
      idle();

      // Read latency
      sram_ce = 1'b0; sram_adv = 1'b0; sram_we = 1'b1; sram_oe = 1'b0;
      sram_addr = 23'h000020;
      #1 chk("lat_edge0", 32'(sram_data), 32'hBAD0);
      @(negedge clk);
      @(negedge clk);
      chk("lat_stab1", 32'(sram_data), 32'hBAD0);
      @(negedge clk);
      chk("lat_stab2", 32'(sram_data), 32'h1234);
      chk("lat_rd_count", 32'(rd_count), 32'h3);
      idle();

      // Short WE pulse is dropped
      wr(23'h000005, 16'h5555, 1'b0, 1'b0, 1'b0, 2);
      wr(23'h000005, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1);
      chk("short_err_code", 32'(err_code), 32'h1);
      chk("short_err", 32'(err), 32'h1);
      chk("short_wr_count", 32'(wr_count), 32'h3);
      rd(23'h000005, 1'b0, 1'b0, got);
      chk("short_mem", 32'(got), 32'h5555);
      idle();
      do_reset();
      chk("rst2_err_code", 32'(err_code), 32'h0);
      chk("rst2_wr_count", 32'(wr_count), 32'h0);

      // Byte lanes
      wr(23'h000007, 16'h2233, 1'b0, 1'b0, 1'b0, 2);
      wr(23'h000007, 16'hFF11, 1'b0, 1'b1, 1'b0, 2);
      wr(23'h001234, 16'hCAFE, 1'b0, 1'b0, 1'b0, 2);
      chk("byte_wr_count", 32'(wr_count), 32'h3);
      rd(23'h000007, 1'b0, 1'b1, got);
      chk("byte_rd_lb", 32'(got), 32'h0011);
      idle();
      rd(23'h000007, 1'b0, 1'b0, got);
      chk("byte_rd_full", 32'(got), 32'h2211);
      idle();

      // Configuration register write
      wr(23'h001234, 16'hDEAD, 1'b0, 1'b0, 1'b1, 2);
      chk("cre_bcr", 32'(bcr), 32'h001234);
      chk("cre_wr_count", 32'(wr_count), 32'h3);
      rd(23'h001234, 1'b0, 1'b0, got);
      chk("cre_array", 32'(got), 32'hCAFE);
      chk("cre_err", 32'(err), 32'h0);
      idle();
      do_reset();
      chk("cre_bcr_rst", 32'(bcr), 32'h009D1F);

      // Address moved mid-pulse: last address wins
      wr(23'h000032, 16'h0101, 1'b0, 1'b0, 1'b0, 2);
      sram_ce = 1'b0; sram_adv = 1'b0; sram_we = 1'b0; sram_oe = 1'b1;
      sram_addr = 23'h000030; tb_dq = 16'h1111; tb_en = 1'b1;
      @(negedge clk);
      sram_addr = 23'h000031;
      @(negedge clk);
      idle();
      chk("tog_err_code", 32'(err_code), 32'h2);
      chk("tog_wr_count", 32'(wr_count), 32'h2);
      rd(23'h000031, 1'b0, 1'b0, got);
      chk("tog_mem", 32'(got), 32'h1111);
      idle();
      do_reset();

      // Reset mid-pulse: nothing committed, no error
      sram_ce = 1'b0; sram_adv = 1'b0; sram_we = 1'b0; sram_oe = 1'b1;
      sram_addr = 23'h000032; tb_dq = 16'h7777; tb_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      idle();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rstmid_err", 32'(err), 32'h0);
      chk("rstmid_wr_count", 32'(wr_count), 32'h0);
      rd(23'h000032, 1'b0, 1'b0, got);
      chk("rstmid_mem", 32'(got), 32'h0101);
      idle();

      // Synchronous-mode attempt
      sram_ce = 1'b0; sram_adv = 1'b0; sram_clk = 1'b1;
      @(negedge clk);
      idle();
      chk("sync_err_code", 32'(err_code), 32'h4);
      chk("sync_err", 32'(err), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
